uart_rx_fifo: RTL and testbench

Receive-side byte buffer that sits directly downstream of the 8-bit UART receiver, on the same 16x-oversample clock. It captures each received byte on the receiver's one-cycle `done` pulse and presents it to the consumer through a first-word-fall-through valid/ready interface. It also records overflow and counts framing errors, so software-facing logic never has to catch the receiver's short-lived output.

---
 rtl/uart_rx_fifo.sv | 121 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO behind the UART receiver: captures bytes on rx_done,
// flags overflow, and counts receiver error edges with saturation.
module uart_rx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_done,
    input  logic                  rx_err,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  overflow,
    output logic [7:0]            err_count,
    input  logic                  clear_flags
);

    localparam int unsigned AW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    logic          full_q, full_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    err_count_q, err_count_d;
    logic          rx_err_dly_q, rx_err_dly_d;

    logic push, pop, push_ok, drop, err_edge;

    // Pointer, occupancy and flag next-state
    always_comb begin
        push         = rx_done;
        pop          = valid_q & out_ready;
        // a full FIFO still accepts a byte when the head leaves in the same cycle
        push_ok      = push & (~full_q | pop);
        drop         = push & full_q & ~pop;
        err_edge     = rx_err & ~rx_err_dly_q;

        wp_d         = wp_q;
        rp_d         = rp_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        err_count_d  = err_count_q;
        rx_err_dly_d = rx_err;

        if (push_ok) begin
            wp_d = wp_q + AW'(1);
        end
        if (pop) begin
            rp_d = rp_q + AW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CW'(1);
        end

        valid_d = (count_d != CW'(0));
        full_d  = (count_d == CW'(DEPTH));

        // clear first so a same-cycle event still registers
        if (clear_flags) begin
            overflow_d  = 1'b0;
            err_count_d = 8'h00;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
        if (err_edge) begin
            if (clear_flags) begin
                err_count_d = 8'h01;
            end else if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'h01;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q         <= '0;
            rp_q         <= '0;
            count_q      <= '0;
            valid_q      <= 1'b0;
            full_q       <= 1'b0;
            overflow_q   <= 1'b0;
            err_count_q  <= 8'h00;
            rx_err_dly_q <= 1'b0;
        end else begin
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            full_q       <= full_d;
            overflow_q   <= overflow_d;
            err_count_q  <= err_count_d;
            rx_err_dly_q <= rx_err_dly_d;
        end
    end

    // Storage array carries no reset; contents are qualified by count
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wp_q] <= rx_data;
        end
    end

    assign out_data  = valid_q ? mem_q[rp_q] : 8'h00;
    assign out_valid = valid_q;
    assign count     = count_q;
    assign full      = full_q;
    assign overflow  = overflow_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH_LOG2 = 4).
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_err;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
    logic       full;
    logic       overflow;
    logic [7:0] err_count;
    logic       clear_flags;

    int ncmp  = 0;
    int nfail = 0;
    logic [7:0] model [$];
    logic [7:0] exp_b;
    int max_cnt;
    int next_v;

    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .rx_err(rx_err),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .full(full), .overflow(overflow), .err_count(err_count),
        .clear_flags(clear_flags)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0; rx_err = 1'b0;
        out_ready = 1'b0; clear_flags = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_err", 32'(err_count), 0);
        rst = 1'b0;
        tick();

        // single byte push then pop
        rx_data = 8'hA5; rx_done = 1'b1; tick(); rx_done = 1'b0;
        chk("push_valid", 32'(out_valid), 1);
        chk("push_data", 32'(out_data), 32'h A5);
        chk("push_count", 32'(count), 1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("pop_valid", 32'(out_valid), 0);
        chk("pop_data", 32'(out_data), 0);
        chk("pop_count", 32'(count), 0);

        // fill, overflow, drain
        for (int i = 0; i < 16; i++) begin
            rx_data = 8'(i); rx_done = 1'b1; tick();
        end
        rx_done = 1'b0;
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 16);
        chk("fill_ovf", 32'(overflow), 0);
        rx_data = 8'hFF; rx_done = 1'b1; tick(); rx_done = 1'b0;
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 16);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", 32'(out_data), 32'(i));
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty", 32'(out_valid), 0);
        chk("drain_count", 32'(count), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        clear_flags = 1'b1; tick(); clear_flags = 1'b0;
        chk("ovf_clear", 32'(overflow), 0);

        // push while full with simultaneous pop
        for (int i = 0; i < 16; i++) begin
            rx_data = 8'(8'h20 + i); rx_done = 1'b1; tick();
        end
        rx_data = 8'h55; out_ready = 1'b1; tick(); rx_done = 1'b0;
        chk("fullpp_ovf", 32'(overflow), 0);
        chk("fullpp_count", 32'(count), 16);
        for (int i = 0; i < 16; i++) begin
            exp_b = (i == 15) ? 8'h55 : 8'(8'h21 + i);
            chk("fullpp_data", 32'(out_data), 32'(exp_b));
            tick();
        end
        out_ready = 1'b0;
        chk("fullpp_empty", 32'(out_valid), 0);

        // push into empty FIFO while consumer is ready: pop ignored
        rx_data = 8'h77; rx_done = 1'b1; out_ready = 1'b1; tick(); rx_done = 1'b0;
        chk("emptypp_count", 32'(count), 1);
        chk("emptypp_data", 32'(out_data), 32'h77);
        tick();
        chk("emptypp_pop", 32'(count), 0);
        out_ready = 1'b0;

        // push and pop with a single entry
        rx_data = 8'h88; rx_done = 1'b1; tick();
        rx_data = 8'h99; out_ready = 1'b1; tick(); rx_done = 1'b0; out_ready = 1'b0;
        chk("one_count", 32'(count), 1);
        chk("one_data", 32'(out_data), 32'h99);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("one_empty", 32'(count), 0);

        // pointer wrap with 3-deep backlog
        max_cnt = 0;
        next_v = 8'h10;
        for (int c = 0; c < 43; c++) begin
            rx_done   = (next_v <= 8'h37);
            rx_data   = 8'(next_v);
            out_ready = (c >= 3);
            if (out_ready) begin
                exp_b = model.pop_front();
                chk("wrap_data", 32'(out_data), 32'(exp_b));
            end
            if (rx_done) begin
                model.push_back(8'(next_v));
                next_v++;
            end
            tick();
            chk("wrap_count", 32'(count), 32'(model.size()));
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        rx_done = 1'b0; out_ready = 1'b0;
        chk("wrap_max_le4", 32'(max_cnt <= 4), 1);
        chk("wrap_empty", 32'(out_valid), 0);

        // receiver error edge counting
        for (int i = 0; i < 3; i++) begin
            rx_err = 1'b1; tick(); rx_err = 1'b0; tick();
        end
        chk("err_3", 32'(err_count), 3);
        rx_err = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rx_err = 1'b0; tick();
        chk("err_held", 32'(err_count), 4);
        for (int i = 0; i < 300; i++) begin
            rx_err = 1'b1; tick(); rx_err = 1'b0; tick();
        end
        chk("err_sat", 32'(err_count), 32'hFF);
        rx_err = 1'b1; clear_flags = 1'b1; tick();
        rx_err = 1'b0; clear_flags = 1'b0;
        chk("err_clr_edge", 32'(err_count), 1);
        tick();
        chk("err_hold", 32'(err_count), 1);

        // asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) begin
            rx_data = 8'(8'hC0 + i); rx_done = 1'b1; tick();
        end
        rx_done = 1'b0;
        chk("arst_pre", 32'(count), 5);
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_data", 32'(out_data), 0);
        chk("arst_err", 32'(err_count), 0);
        #1 rst = 1'b0;
        tick();
        rx_data = 8'h3C; rx_done = 1'b1; tick(); rx_done = 1'b0;
        chk("arst_push_data", 32'(out_data), 32'h3C);
        chk("arst_push_count", 32'(count), 1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("arst_final", 32'(out_valid), 0);
        chk("arst_final_cnt", 32'(count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
